// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX->MEM register stage with 2-entry skid buffer, branch
//            resolution from ALU flags, fetch redirect and taken counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic [RA_W-1:0]  rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [XLEN-1:0]  store_data,
    input  logic [2:0]       funct3,
    input  logic             is_branch,
    input  logic [XLEN-1:0]  br_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [XLEN-1:0]  out_store_data,
    output logic [2:0]       out_funct3,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [RA_W-1:0] rd;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } pkt_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pkt_t             r_main;
    pkt_t             r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_taken_cnt;

    pkt_t             w_in_pkt;
    logic             w_accept;
    logic             w_drain;
    logic             w_cond;
    logic             w_br_taken;

    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & ~r_skid_valid & ~flush;
    assign w_drain  = r_main_valid & out_ready;

    // BLTU/BGEU use C as "no borrow" from the SUB the ALU performed
    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:  w_cond = alu_z;
            3'b001:  w_cond = ~alu_z;
            3'b100:  w_cond = alu_n ^ alu_v;
            3'b101:  w_cond = ~(alu_n ^ alu_v);
            3'b110:  w_cond = ~alu_c;
            3'b111:  w_cond = alu_c;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_taken = w_accept & is_branch & w_cond;

    always_comb begin
        w_in_pkt.result     = alu_result;
        w_in_pkt.store_data = store_data;
        w_in_pkt.rd         = rd;
        w_in_pkt.funct3     = funct3;
        w_in_pkt.reg_write  = reg_write & ~is_branch;
        w_in_pkt.mem_read   = mem_read  & ~is_branch;
        w_in_pkt.mem_write  = mem_write & ~is_branch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_drain && r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept && (!r_main_valid || w_drain)) begin
                r_main       <= w_in_pkt;
                r_main_valid <= 1'b1;
            end else if (w_drain) begin
                r_main_valid <= 1'b0;
            end
            // Main is busy and stalled: park the newcomer behind it
            if (w_accept && r_main_valid && !w_drain) begin
                r_skid       <= w_in_pkt;
                r_skid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_taken_cnt      <= '0;
        end else begin
            r_redirect_valid <= w_br_taken;
            r_redirect_pc    <= w_br_taken ? br_target : '0;
            if (w_br_taken) begin
                r_taken_cnt <= r_taken_cnt + c_CNT_ONE;
            end
        end
    end

    assign out_valid      = r_main_valid;
    assign out_result     = r_main.result;
    assign out_rd         = r_main.rd;
    assign out_reg_write  = r_main.reg_write;
    assign out_mem_read   = r_main.mem_read;
    assign out_mem_write  = r_main.mem_write;
    assign out_store_data = r_main.store_data;
    assign out_funct3     = r_main.funct3;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign taken_cnt      = r_taken_cnt;

endmodule
`default_nettype wire
